// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit: opcodes, bus-select codes,
// FSM state encoding and instruction-field positions.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam logic [3:0] SEL_PC   = 4'd7;
    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_DIN  = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;

    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_RX_HI = 5;
    localparam int IR_RX_LO = 3;
    localparam int IR_RY_HI = 2;
    localparam int IR_RY_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_FW,
        S_F2,
        S_T3,
        S_T4,
        S_TW,
        S_T5
    } state_t;

endpackage

// File: rtl/proc_wait_counter.sv
// Memory wait-state counter shared by the fetch and execute wait states;
// zero_o tells the FSM the last wait cycle has been reached.
module proc_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wait_i,
    output logic zero_o
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign zero_o = (cnt_q == '0);

    // Preloaded on every non-wait cycle so a wait state always starts full.
    always_comb begin
        cnt_d = LOAD;
        if (wait_i && !zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Instruction-sequencing control unit: fetches into IR, decodes, and steps a
// Moore FSM that drives every datapath strobe with a one-cycle Done per instruction.
module proc_control
    import proc_pkg::*;
#(
    parameter int DW      = 16,
    parameter int IW      = 9,
    parameter int MEM_LAT = 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    input  logic          GNZ,
    output logic [7:0]    Rin,
    output logic          Ain,
    output logic          Gin,
    output logic          AddSub,
    output logic [3:0]    BusSel,
    output logic          ADDRin,
    output logic          DOUTin,
    output logic          W_D,
    output logic          IncrPC,
    output logic          Done
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [2:0]    op, rx, ry;
    logic          in_wait, wait_zero, last_cycle;
    logic          unused_din;

    assign unused_din = ^DIN[DW-1:IW];

    assign op = ir_q[IR_OP_HI:IR_OP_LO];
    assign rx = ir_q[IR_RX_HI:IR_RX_LO];
    assign ry = ir_q[IR_RY_HI:IR_RY_LO];

    assign in_wait = (state_q == S_FW) || (state_q == S_TW);
    assign ir_d    = (state_q == S_F2) ? DIN[IW-1:0] : ir_q;

    // Final execute cycle of the current instruction; shared by Done and sequencing.
    assign last_cycle = (state_q == S_T5)
                     || ((state_q == S_T4) && (op == OP_ST))
                     || ((state_q == S_T3) && ((op == OP_MV) || (op == OP_MVNZ) || (op == OP_RSV)));

    proc_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .wait_i (in_wait),
        .zero_o (wait_zero)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (last_cycle) begin
            state_d = Run ? S_F0 : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = Run ? S_F0 : S_IDLE;
                S_F0:   state_d = S_FW;
                S_FW:   state_d = wait_zero ? S_F2 : S_FW;
                S_F2:   state_d = S_T3;
                S_T3:   state_d = ((op == OP_MVI) || (op == OP_LD)) ? S_TW : S_T4;
                S_T4:   state_d = S_T5;
                S_TW:   state_d = wait_zero ? S_T5 : S_TW;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Rin    = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        BusSel = SEL_NONE;
        ADDRin = 1'b0;
        DOUTin = 1'b0;
        W_D    = 1'b0;
        IncrPC = 1'b0;
        Done   = last_cycle;
        unique case (state_q)
            S_F0: begin
                BusSel = SEL_PC;
                ADDRin = 1'b1;
                IncrPC = 1'b1;
            end
            S_T3: begin
                unique case (op)
                    OP_MV: begin
                        BusSel = {1'b0, ry};
                        Rin    = 8'b1 << rx;
                    end
                    OP_MVI: begin
                        BusSel = SEL_PC;
                        ADDRin = 1'b1;
                        IncrPC = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        BusSel = {1'b0, rx};
                        Ain    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        BusSel = {1'b0, ry};
                        ADDRin = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (GNZ) begin
                            BusSel = {1'b0, ry};
                            Rin    = 8'b1 << rx;
                        end
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                if (op == OP_ST) begin
                    BusSel = {1'b0, rx};
                    DOUTin = 1'b1;
                    W_D    = 1'b1;
                end else begin
                    BusSel = {1'b0, ry};
                    Gin    = 1'b1;
                    AddSub = (op == OP_SUB);
                end
            end
            S_T5: begin
                BusSel = ((op == OP_ADD) || (op == OP_SUB)) ? SEL_G : SEL_DIN;
                Rin    = 8'b1 << rx;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control: per-instruction cycle-by-cycle strobe tables,
// reset behaviour, back-to-back execution and a MEM_LAT = 2 instance.
module tb_proc_control;

    localparam int DW = 16;

    logic          Clock = 1'b0;
    logic          Resetn, Run, Run2, GNZ;
    logic [DW-1:0] DIN;

    logic [7:0] Rin, Rin2;
    logic       Ain, Gin, AddSub, ADDRin, DOUTin, W_D, IncrPC, Done;
    logic       Ain2, Gin2, AddSub2, ADDRin2, DOUTin2, W_D2, IncrPC2, Done2;
    logic [3:0] BusSel, BusSel2;

    logic [19:0] obs, obs2;
    logic [19:0] QV, F0V;

    int n_checks = 0;
    int n_fails  = 0;

    assign obs  = {Rin, Ain, Gin, AddSub, BusSel, ADDRin, DOUTin, W_D, IncrPC, Done};
    assign obs2 = {Rin2, Ain2, Gin2, AddSub2, BusSel2, ADDRin2, DOUTin2, W_D2, IncrPC2, Done2};

    always #5 Clock = ~Clock;

    proc_control #(.DW(DW), .IW(9), .MEM_LAT(1)) dut (
        .Clock (Clock), .Resetn (Resetn), .Run (Run), .DIN (DIN), .GNZ (GNZ),
        .Rin (Rin), .Ain (Ain), .Gin (Gin), .AddSub (AddSub), .BusSel (BusSel),
        .ADDRin (ADDRin), .DOUTin (DOUTin), .W_D (W_D), .IncrPC (IncrPC), .Done (Done)
    );

    proc_control #(.DW(DW), .IW(9), .MEM_LAT(2)) dut2 (
        .Clock (Clock), .Resetn (Resetn), .Run (Run2), .DIN (DIN), .GNZ (GNZ),
        .Rin (Rin2), .Ain (Ain2), .Gin (Gin2), .AddSub (AddSub2), .BusSel (BusSel2),
        .ADDRin (ADDRin2), .DOUTin (DOUTin2), .W_D (W_D2), .IncrPC (IncrPC2), .Done (Done2)
    );

    // Packs an expected output set in the same order as obs.
    function automatic logic [19:0] ev(input logic [7:0] rin, input logic a, input logic g,
                                       input logic s, input logic [3:0] bs, input logic ad,
                                       input logic dq, input logic w, input logic inc,
                                       input logic dn);
        return {rin, a, g, s, bs, ad, dq, w, inc, dn};
    endfunction

    task automatic test_reset();
        Resetn = 1'b0; Run = 1'b0; Run2 = 1'b0; GNZ = 1'b0; DIN = '0;
        repeat (3) @(posedge Clock);
        #1;
        n_checks++;
        if (obs !== QV) begin
            n_fails++; $display("FAIL reset_outputs: got %h expected %h", obs, QV);
        end
        n_checks++;
        if (obs2 !== QV) begin
            n_fails++; $display("FAIL reset_outputs_lat2: got %h expected %h", obs2, QV);
        end
        n_checks++;
        if (dut.ir_q !== 9'd0) begin
            n_fails++; $display("FAIL reset_ir: got %h expected 000", dut.ir_q);
        end
        Resetn = 1'b1;
        @(posedge Clock); #1;
        n_checks++;
        if (obs !== QV) begin
            n_fails++; $display("FAIL idle_hold: got %h expected %h", obs, QV);
        end
    endtask

    task automatic test_add();
        logic [19:0] exp [0:6];
        exp = '{F0V, QV, QV,
                ev(8'h00, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0),
                ev(8'h00, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0),
                ev(8'h01, 0, 0, 0, 4'd8, 0, 0, 0, 0, 1),
                QV};
        DIN = 16'(9'o202); Run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL add cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_sub();
        logic [19:0] exp [0:6];
        exp = '{F0V, QV, QV,
                ev(8'h00, 1, 0, 0, 4'd1, 0, 0, 0, 0, 0),
                ev(8'h00, 0, 1, 1, 4'd2, 0, 0, 0, 0, 0),
                ev(8'h02, 0, 0, 0, 4'd8, 0, 0, 0, 0, 1),
                QV};
        DIN = 16'(9'o312); Run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL sub cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_mvi();
        logic [19:0] exp [0:6];
        exp = '{F0V, QV, QV,
                ev(8'h00, 0, 0, 0, 4'd7, 1, 0, 0, 1, 0),
                QV,
                ev(8'h08, 0, 0, 0, 4'd9, 0, 0, 0, 0, 1),
                QV};
        DIN = 16'(9'o130); Run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            if (c == 3) DIN = 16'h00AB;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL mvi cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_ld();
        logic [19:0] exp [0:6];
        exp = '{F0V, QV, QV,
                ev(8'h00, 0, 0, 0, 4'd5, 1, 0, 0, 0, 0),
                QV,
                ev(8'h40, 0, 0, 0, 4'd9, 0, 0, 0, 0, 1),
                QV};
        DIN = 16'(9'o465); Run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL ld cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_st();
        logic [19:0] exp [0:5];
        exp = '{F0V, QV, QV,
                ev(8'h00, 0, 0, 0, 4'd4, 1, 0, 0, 0, 0),
                ev(8'h00, 0, 0, 0, 4'd1, 0, 1, 1, 0, 1),
                QV};
        DIN = 16'(9'o514); Run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL st cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_mvnz_rsv();
        logic [19:0] exp [0:4];
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                GNZ = 1'b0; DIN = 16'(9'o656);
                exp = '{F0V, QV, QV, ev(8'h00, 0, 0, 0, 4'd15, 0, 0, 0, 0, 1), QV};
            end else if (k == 1) begin
                GNZ = 1'b1; DIN = 16'(9'o656);
                exp = '{F0V, QV, QV, ev(8'h20, 0, 0, 0, 4'd6, 0, 0, 0, 0, 1), QV};
            end else begin
                GNZ = 1'b1; DIN = 16'(9'o777);
                exp = '{F0V, QV, QV, ev(8'h00, 0, 0, 0, 4'd15, 0, 0, 0, 0, 1), QV};
            end
            Run = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge Clock); #1;
                Run = 1'b0;
                n_checks++;
                if (obs !== exp[c]) begin
                    n_fails++;
                    $display("FAIL mvnz_rsv run %0d cycle %0d: got %h expected %h", k, c, obs, exp[c]);
                end
            end
        end
        GNZ = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp [0:8];
        logic [19:0] t3;
        t3  = ev(8'h80, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
        exp = '{F0V, QV, QV, t3, F0V, QV, QV, t3, QV};
        DIN = 16'(9'o070); Run = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge Clock); #1;
            if (c >= 4) Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL b2b cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
    endtask

    task automatic test_reset_mid_add();
        logic [19:0] exp [0:5];
        exp = '{F0V, QV, QV,
                ev(8'h00, 1, 0, 0, 4'd0, 0, 0, 0, 0, 0),
                ev(8'h00, 0, 1, 0, 4'd2, 0, 0, 0, 0, 0),
                ev(8'h01, 0, 0, 0, 4'd8, 0, 0, 0, 0, 1)};
        DIN = 16'(9'o202); Run = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL rst_mid pre cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
        Resetn = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        n_checks++;
        if (obs !== QV) begin
            n_fails++; $display("FAIL rst_mid_idle: got %h expected %h", obs, QV);
        end
        n_checks++;
        if (dut.ir_q !== 9'd0) begin
            n_fails++; $display("FAIL rst_mid_ir: got %h expected 000", dut.ir_q);
        end
        Run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clock); #1;
            Run = 1'b0;
            n_checks++;
            if (obs !== exp[c]) begin
                n_fails++; $display("FAIL rst_mid restart cycle %0d: got %h expected %h", c, obs, exp[c]);
            end
        end
        @(posedge Clock); #1;
        n_checks++;
        if (obs !== QV) begin
            n_fails++; $display("FAIL rst_mid_end: got %h expected %h", obs, QV);
        end
    endtask

    task automatic test_mem_lat2();
        logic [19:0] exp [0:5];
        exp = '{F0V, QV, QV, QV, ev(8'h80, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1), QV};
        DIN = 16'(9'o070); Run2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clock); #1;
            Run2 = 1'b0;
            n_checks++;
            if (obs2 !== exp[c]) begin
                n_fails++; $display("FAIL lat2 cycle %0d: got %h expected %h", c, obs2, exp[c]);
            end
        end
    endtask

    initial begin
        QV  = ev(8'h00, 0, 0, 0, 4'd15, 0, 0, 0, 0, 0);
        F0V = ev(8'h00, 0, 0, 0, 4'd7, 1, 0, 0, 1, 0);
        test_reset();
        test_add();
        test_sub();
        test_mvi();
        test_ld();
        test_st();
        test_mvnz_rsv();
        test_back_to_back();
        test_reset_mid_add();
        test_mem_lat2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
